// File: rtl/quan_deskew_regs_v3.sv
// Column deskew buffer: delays lane c by 1+SKEW_STEP*c (or the mirror index) enabled cycles.
// Latency 1..DMAX enabled cycles per lane; en=0 freezes every register, with no ready/credit path.
// Direction changes are applied only while the block is empty.
module quan_deskew_regs_v3 #(
    parameter int COLS         = 16,
    parameter int LANE_W       = 64,
    parameter int SKEW_STEP    = 1,
    parameter int ZERO_INVALID = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     skew_dir,
    input  logic [COLS-1:0]          in_valid,
    input  logic [COLS*LANE_W-1:0]   sum_row,
    output logic [COLS*LANE_W-1:0]   delay_sum_row,
    output logic [COLS-1:0]          out_valid,
    output logic                     out_row_valid,
    output logic                     busy,
    output logic                     dir_active
);

    localparam int DMAX = 1 + SKEW_STEP * (COLS - 1);
    localparam int NST  = DMAX - 1;

    logic                   dir_next;
    logic                   chain_busy;
    logic [COLS-1:0]        tap_v;
    logic [COLS*LANE_W-1:0] tap_d;
    logic [COLS-1:0]        nxt_v;
    logic [COLS*LANE_W-1:0] nxt_d;

    assign busy = chain_busy | (|out_valid);

    // Taps follow the direction that will be active after this edge. A switch
    // only happens with an empty chain, so only the direct lane sees the difference.
    assign dir_next = (en && !busy) ? skew_dir : dir_active;

    generate
        if (NST > 0) begin : g_chain
            logic [COLS-1:0]        ch_v [NST];
            logic [COLS*LANE_W-1:0] ch_d [NST];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < NST; i++) begin
                        ch_v[i] <= '0;
                        ch_d[i] <= '0;
                    end
                end else if (en) begin
                    ch_v[0] <= in_valid;
                    ch_d[0] <= sum_row;
                    for (int i = 1; i < NST; i++) begin
                        ch_v[i] <= ch_v[i-1];
                        ch_d[i] <= ch_d[i-1];
                    end
                end
            end

            always_comb begin
                chain_busy = 1'b0;
                for (int i = 0; i < NST; i++) begin
                    chain_busy = chain_busy | (|ch_v[i]);
                end
            end

            for (genvar c = 0; c < COLS; c++) begin : g_lane
                localparam int DA = 1 + SKEW_STEP * c;
                localparam int DD = 1 + SKEW_STEP * (COLS - 1 - c);
                logic              va;
                logic              vd;
                logic [LANE_W-1:0] da;
                logic [LANE_W-1:0] dd;

                // Stage index i holds data that entered i+1 enabled cycles ago.
                if (DA == 1) begin : g_a_direct
                    assign va = in_valid[c];
                    assign da = sum_row[c*LANE_W +: LANE_W];
                end else begin : g_a_tap
                    assign va = ch_v[DA-2][c];
                    assign da = ch_d[DA-2][c*LANE_W +: LANE_W];
                end

                if (DD == 1) begin : g_d_direct
                    assign vd = in_valid[c];
                    assign dd = sum_row[c*LANE_W +: LANE_W];
                end else begin : g_d_tap
                    assign vd = ch_v[DD-2][c];
                    assign dd = ch_d[DD-2][c*LANE_W +: LANE_W];
                end

                assign tap_v[c]                    = dir_next ? vd : va;
                assign tap_d[c*LANE_W +: LANE_W]   = dir_next ? dd : da;
            end
        end else begin : g_nochain
            assign chain_busy = 1'b0;
            assign tap_v      = in_valid;
            assign tap_d      = sum_row;
        end
    endgenerate

    always_comb begin
        nxt_v = tap_v;
        nxt_d = tap_d;
        for (int c = 0; c < COLS; c++) begin
            if (ZERO_INVALID != 0 && !tap_v[c]) begin
                nxt_d[c*LANE_W +: LANE_W] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= '0;
            delay_sum_row <= '0;
            out_row_valid <= 1'b0;
            dir_active    <= 1'b0;
        end else if (en) begin
            out_valid     <= nxt_v;
            delay_sum_row <= nxt_d;
            out_row_valid <= &nxt_v;
            dir_active    <= dir_next;
        end
    end

endmodule

// File: tb/tb_quan_deskew_regs_v3.sv
// Scoreboarded bench: a history-of-inputs reference model feeds an expectation queue.
// A negedge monitor compares both DUT configurations against it.
module tb_quan_deskew_regs_v3;

    localparam int COLS = 16;
    localparam int LW   = 64;
    localparam int SS   = 1;
    localparam int DW   = COLS * LW;
    localparam int DMAX = 1 + SS * (COLS - 1);

    logic            clk;
    logic            rst;
    logic            en;
    logic            skew_dir;
    logic [COLS-1:0] in_valid;
    logic [DW-1:0]   sum_row;
    logic [DW-1:0]   delay_sum_row;
    logic [COLS-1:0] out_valid;
    logic            out_row_valid;
    logic            busy;
    logic            dir_active;

    logic [3:0]      in_valid2;
    logic [31:0]     sum_row2;
    logic [31:0]     delay_sum_row2;
    logic [3:0]      out_valid2;
    logic            out_row_valid2;
    logic            busy2;
    logic            dir_active2;

    quan_deskew_regs_v3 #(.COLS(COLS), .LANE_W(LW), .SKEW_STEP(SS), .ZERO_INVALID(1)) dut (
        .clk(clk), .rst(rst), .en(en), .skew_dir(skew_dir),
        .in_valid(in_valid), .sum_row(sum_row),
        .delay_sum_row(delay_sum_row), .out_valid(out_valid),
        .out_row_valid(out_row_valid), .busy(busy), .dir_active(dir_active)
    );

    quan_deskew_regs_v3 #(.COLS(4), .LANE_W(8), .SKEW_STEP(0), .ZERO_INVALID(1)) dut2 (
        .clk(clk), .rst(rst), .en(en), .skew_dir(skew_dir),
        .in_valid(in_valid2), .sum_row(sum_row2),
        .delay_sum_row(delay_sum_row2), .out_valid(out_valid2),
        .out_row_valid(out_row_valid2), .busy(busy2), .dir_active(dir_active2)
    );

    typedef struct {
        logic [COLS-1:0] v;
        logic [DW-1:0]   d;
    } ent_t;

    typedef struct {
        logic [COLS-1:0] v;
        logic [DW-1:0]   d;
        logic            busy;
        logic            dir;
        logic [3:0]      v2;
        logic [31:0]     d2;
    } exp_t;

    ent_t hist[$];
    exp_t expq[$];
    exp_t e;

    logic [COLS-1:0] m_v;
    logic [DW-1:0]   m_d;
    logic            m_dir;
    logic [3:0]      m2_v;
    logic [31:0]     m2_d;

    int n_tests = 0;
    int n_fail  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endfunction

    function automatic int dly(int c, logic dir);
        return dir ? 1 + SS * (COLS - 1 - c) : 1 + SS * c;
    endfunction

    // Something is in flight if any valid entered within the last DMAX-1 enabled
    // cycles (still inside a chain) or an output lane currently holds a valid.
    function automatic logic model_busy();
        logic b;
        b = |m_v;
        for (int k = 0; k < DMAX - 1; k++) begin
            if (k < hist.size()) b = b | (|hist[k].v);
        end
        return b;
    endfunction

    function automatic logic [DW-1:0] rnd_row();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [DW-1:0] pulse_row();
        logic [DW-1:0] r;
        for (int c = 0; c < COLS; c++) r[c*LW +: LW] = 64'h1000 + 64'(c);
        return r;
    endfunction

    task automatic step(input logic e_in, input logic dir, input logic [COLS-1:0] v, input logic [DW-1:0] d);
        logic [3:0]  v2;
        logic [31:0] d2;
        exp_t        x;
        v2 = 4'($urandom);
        d2 = $urandom;
        en = e_in; skew_dir = dir; in_valid = v; sum_row = d;
        in_valid2 = v2; sum_row2 = d2;
        if (e_in) begin
            if (!model_busy()) m_dir = dir;
            hist.push_front('{v: v, d: d});
            if (hist.size() > DMAX) void'(hist.pop_back());
            for (int c = 0; c < COLS; c++) begin
                int k;
                k = dly(c, m_dir) - 1;
                m_v[c] = 1'b0;
                m_d[c*LW +: LW] = '0;
                if (k < hist.size() && hist[k].v[c]) begin
                    m_v[c] = 1'b1;
                    m_d[c*LW +: LW] = hist[k].d[c*LW +: LW];
                end
            end
            m2_v = v2;
            for (int c = 0; c < 4; c++) m2_d[c*8 +: 8] = v2[c] ? d2[c*8 +: 8] : 8'h00;
        end
        x.v = m_v; x.d = m_d; x.busy = model_busy(); x.dir = m_dir;
        x.v2 = m2_v; x.d2 = m2_d;
        expq.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic dir);
        for (int i = 0; i < n; i++) step(1'b1, dir, '0, rnd_row());
    endtask

    always @(negedge clk) begin
        if (!rst && expq.size() > 0) begin
            e = expq.pop_front();
            chk("out_valid", 64'(out_valid), 64'(e.v));
            for (int c = 0; c < COLS; c++)
                chk($sformatf("lane%0d_data", c), delay_sum_row[c*LW +: LW], e.d[c*LW +: LW]);
            chk("out_row_valid", 64'(out_row_valid), 64'(&e.v));
            chk("busy", 64'(busy), 64'(e.busy));
            chk("dir_active", 64'(dir_active), 64'(e.dir));
            chk("s0_out_valid", 64'(out_valid2), 64'(e.v2));
            chk("s0_data", 64'(delay_sum_row2), 64'(e.d2));
            chk("s0_row_valid", 64'(out_row_valid2), 64'(&e.v2));
            chk("s0_busy", 64'(busy2), 64'(|e.v2));
        end
    end

    initial begin
        logic dr;
        rst = 1'b1; en = 1'b0; skew_dir = 1'b0;
        in_valid = '0; sum_row = '0; in_valid2 = '0; sum_row2 = '0;
        m_v = '0; m_d = '0; m_dir = 1'b0; m2_v = '0; m2_d = '0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_data_or", 64'(|delay_sum_row), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_dir", 64'(dir_active), 64'd0);
        chk("rst_s0_valid", 64'(out_valid2), 64'd0);
        #1 rst = 1'b0;

        // ascending latency
        step(1'b1, 1'b0, '1, pulse_row());
        idle(20, 1'b0);

        // same pulse with a three-cycle stall
        step(1'b1, 1'b0, '1, pulse_row());
        idle(2, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '1, rnd_row());
        idle(20, 1'b0);

        // alignment: lane c fed at cycle 15-c
        for (int t = 0; t < COLS; t++) step(1'b1, 1'b0, 16'(1 << (COLS - 1 - t)), pulse_row());
        idle(20, 1'b0);

        // direction request raised while busy
        step(1'b1, 1'b0, '1, pulse_row());
        idle(25, 1'b1);
        step(1'b1, 1'b1, '1, pulse_row());
        idle(20, 1'b1);

        // randomized traffic with stalls, bubbles and occasional direction flips
        dr = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) dr = ~dr;
            step($urandom_range(0, 3) != 0, dr,
                 ($urandom_range(0, 2) == 0) ? '0 : 16'($urandom), rnd_row());
        end

        // async reset mid-flight, between edges
        step(1'b1, dr, '1, pulse_row());
        for (int i = 0; i < 4; i++) step(1'b1, dr, 16'($urandom), rnd_row());
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_data_or", 64'(|delay_sum_row), 64'd0);
        chk("arst_row_valid", 64'(out_row_valid), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_dir", 64'(dir_active), 64'd0);
        chk("arst_s0_valid", 64'(out_valid2), 64'd0);
        hist.delete();
        expq.delete();
        m_v = '0; m_d = '0; m_dir = 1'b0; m2_v = '0; m2_d = '0;
        #1 rst = 1'b0;
        idle(20, 1'b0);

        // fresh ascending pulse after reset
        step(1'b1, 1'b0, '1, pulse_row());
        idle(20, 1'b0);

        @(negedge clk);
        #1;
        if (expq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
